// File: rtl/spi_pkg.sv
// Shared SPI definitions: bus mode encodings, responder FSM states, default word width.
// Imported by spi_sync and spi_slave.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    // Modes as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// 2-FF synchroniser plus edge-detect register; edges reach the user 3 clk edges after the pin moves.
// No backpressure: level/rise/fall are free-running observations of the pin.
module spi_sync
    import spi_pkg::*;
#(
    parameter bit IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= IDLE;
            sync_q <= IDLE;
            prev_q <= IDLE;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder oversampling SCLK/MOSI/CS in clk; rx word appears 3-4 clk after its last sample edge.
// Single-entry tx holding register: tx_ready low while full; an empty register at a word load sends zeros and flags underrun.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  CS,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  underrun,
    output logic                  frame_err
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;
    logic cs_level, cs_rise, cs_fall;

    spi_sync #(.IDLE(CPOL)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(SCLK),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.IDLE(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(MOSI),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_sync #(.IDLE(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(CS),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_state_t            state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full_q;
    logic                  miso_q;
    logic                  skip_q;
    logic                  reload_q;
    logic [1:0]            warm_q;
    logic                  armed_q;
    logic                  load_en;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic in_shift, sample_now, word_done, shift_now, reload_now, advance;

    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign in_shift   = (state_q == ST_SHIFT);
    assign sample_now = in_shift && sample_edge;
    assign word_done  = sample_now && (bit_cnt_q == LAST_BIT);
    assign shift_now  = in_shift && shift_edge && !cs_rise;
    assign reload_now = load_en || (!CPHA && word_done && !cs_rise) || (shift_now && reload_q);
    assign advance    = shift_now && !reload_q && !skip_q;

    // CS may already be low when reset releases; a frame only starts after CS has been seen high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            warm_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            if (warm_q != 2'd3)
                warm_q <= warm_q + 2'd1;
            if (warm_q == 2'd3 && cs_level)
                armed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (cs_fall && armed_q) state_d = ST_LOAD;
            ST_LOAD: begin
                state_d = ST_SHIFT;
                load_en = 1'b1;
            end
            ST_SHIFT: state_d = ST_SHIFT;
            default:  state_d = ST_IDLE;
        endcase
        if (cs_rise) begin
            state_d = ST_IDLE;
            load_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            skip_q      <= 1'b0;
            reload_q    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            underrun    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;

            // Write needs an empty register, consume needs a full one: never both.
            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            if (reload_now) begin
                if (hold_full_q) begin
                    tx_shift_q  <= hold_q;
                    miso_q      <= hold_q[DATA_WIDTH-1];
                    hold_full_q <= 1'b0;
                end else begin
                    tx_shift_q <= '0;
                    miso_q     <= 1'b0;
                    underrun   <= 1'b1;
                end
            end else if (advance) begin
                tx_shift_q <= tx_shift_q << 1;
                miso_q     <= tx_shift_q[DATA_WIDTH-2];
            end

            if (load_en) begin
                bit_cnt_q <= '0;
                skip_q    <= CPHA;
                reload_q  <= 1'b0;
            end

            if (shift_now) begin
                skip_q   <= 1'b0;
                reload_q <= 1'b0;
            end

            if (sample_now) begin
                rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_level};
                if (word_done) begin
                    rx_data   <= {rx_shift_q[DATA_WIDTH-2:0], mosi_level};
                    rx_valid  <= 1'b1;
                    bit_cnt_q <= '0;
                    // Mode 0/2 already reloaded, so its next trailing edge must hold the new MSB.
                    if (!cs_rise) begin
                        skip_q   <= !CPHA;
                        reload_q <= CPHA;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end

            if (cs_rise) begin
                if (state_q != ST_IDLE && bit_cnt_q != '0 && !word_done)
                    frame_err <= 1'b1;
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
                tx_shift_q <= '0;
                miso_q     <= 1'b0;
                skip_q     <= 1'b0;
                reload_q   <= 1'b0;
            end
        end
    end

    assign MISO     = miso_q;
    assign tx_ready = !hold_full_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Drives one spi_slave per SPI mode from a behavioural bus master and checks against a word-level model.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int DW   = 8;
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          mosi;
    logic [3:0]    cs;
    logic [DW-1:0] tx_data;
    logic [3:0]    tx_valid;
    logic [3:0]    miso, tx_ready, rx_valid, busy, underrun, frame_err;
    logic [DW-1:0] rx_data [4];

    logic cpol;
    logic cpha;

    int vectors     = 0;
    int miscompares = 0;

    int rxv_cnt  = 0;
    int und_cnt  = 0;
    int ferr_cnt = 0;
    logic [DW-1:0] rx_log[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .DATA_WIDTH(DW),
            .CPOL(bit'(g / 2)),
            .CPHA(bit'(g % 2))
        ) u_dut (
            .clk(clk), .rst(rst), .SCLK(sclk), .MOSI(mosi), .CS(cs[g]),
            .MISO(miso[g]), .tx_data(tx_data), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
            .busy(busy[g]), .underrun(underrun[g]), .frame_err(frame_err[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_valid[k]) begin
                rxv_cnt++;
                rx_log.push_back(rx_data[k]);
            end
            if (underrun[k])  und_cnt++;
            if (frame_err[k]) ferr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input logic [DW-1:0] d);
        chk("tx_ready_before_push", 32'(tx_ready[m]), 32'(1));
        tx_data     = d;
        tx_valid[m] = 1'b1;
        tick(1);
        tx_valid[m] = 1'b0;
        chk("tx_ready_after_push", 32'(tx_ready[m]), 32'(0));
    endtask

    // One SCLK period as the master sees it; returns the MISO bit sampled at the master's sample edge.
    task automatic sclk_cycle(input int m, input logic b, output logic got);
        if (!cpha) begin
            mosi = b;
            tick(HALF);
            got  = miso[m];
            sclk = ~cpol;
            tick(HALF);
            sclk = cpol;
        end else begin
            tick(HALF);
            sclk = ~cpol;
            mosi = b;
            tick(HALF);
            got  = miso[m];
            sclk = cpol;
        end
    endtask

    // abort_bits < 0 runs nw full words; otherwise CS rises after abort_bits SCLK periods.
    task automatic run_frame(input int m, input int nw, input logic [DW-1:0] rxw0, input logic [DW-1:0] rxw1,
                             input int nsup, input logic [DW-1:0] txw0, input logic [DW-1:0] txw1,
                             input int abort_bits);
        int            rxv0, und0, ferr0, log0;
        int            bits, completed, begun, loads, exp_und;
        logic [DW-1:0] prev_rx, got0, got1, exp_got;
        logic          g;
        bit            abort;

        abort   = (abort_bits >= 0);
        rxv0    = rxv_cnt;
        und0    = und_cnt;
        ferr0   = ferr_cnt;
        log0    = rx_log.size();
        prev_rx = rx_data[m];
        got0    = '0;
        got1    = '0;

        cpol = ((m / 2) != 0);
        cpha = ((m % 2) != 0);
        sclk = cpol;
        mosi = 1'b0;
        tick(8);

        if (nsup >= 1) push(m, txw0);
        else           chk("holding_empty_at_start", 32'(tx_ready[m]), 32'(1));

        cs[m] = 1'b0;
        tick(10);
        chk("busy_in_frame", 32'(busy[m]), 32'(1));

        bits = abort ? abort_bits : nw * DW;
        for (int i = 0; i < bits; i++) begin
            int w  = i / DW;
            int bi = DW - 1 - (i % DW);
            sclk_cycle(m, (w == 0) ? rxw0[bi] : rxw1[bi], g);
            if (w == 0) got0[bi] = g;
            else        got1[bi] = g;
            if (i == 3 && nsup == 2) push(m, txw1);
        end

        tick(HALF);
        cs[m] = 1'b1;
        tick(10);

        // A word load happens at CS fall and again at each word boundary (CPHA=0)
        // or only when a further word actually starts (CPHA=1).
        completed = bits / DW;
        begun     = (bits + DW - 1) / DW;
        if (begun == 0) begun = 1;
        loads     = cpha ? begun : 1 + completed;
        exp_und   = (loads > nsup) ? loads - nsup : 0;

        chk("busy_after_frame", 32'(busy[m]), 32'(0));
        chk("miso_idle", 32'(miso[m]), 32'(0));
        chk("rx_valid_pulses", 32'(rxv_cnt - rxv0), 32'(completed));
        chk("underrun_pulses", 32'(und_cnt - und0), 32'(exp_und));
        chk("frame_err_pulses", 32'(ferr_cnt - ferr0), 32'((abort && (bits % DW) != 0) ? 1 : 0));

        if (completed >= 1) begin
            exp_got = (nsup >= 1) ? txw0 : '0;
            chk("master_rx_word0", 32'(got0), 32'(exp_got));
            if (rx_log.size() > log0) chk("slave_rx_word0", 32'(rx_log[log0]), 32'(rxw0));
        end
        if (completed >= 2) begin
            exp_got = (nsup >= 2) ? txw1 : '0;
            chk("master_rx_word1", 32'(got1), 32'(exp_got));
            if (rx_log.size() > log0 + 1) chk("slave_rx_word1", 32'(rx_log[log0 + 1]), 32'(rxw1));
        end
        if (completed == 0)      chk("rx_data_kept", 32'(rx_data[m]), 32'(prev_rx));
        else if (completed == 1) chk("rx_data_final", 32'(rx_data[m]), 32'(rxw0));
        else                     chk("rx_data_final", 32'(rx_data[m]), 32'(rxw1));
    endtask

    initial begin
        logic g;
        int   rxv0, ferr0;

        rst      = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        cs       = 4'hF;
        tx_valid = 4'h0;
        tx_data  = '0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tick(4);

        for (int k = 0; k < 4; k++) begin
            chk("reset_miso", 32'(miso[k]), 32'(0));
            chk("reset_tx_ready", 32'(tx_ready[k]), 32'(1));
            chk("reset_rx_data", 32'(rx_data[k]), 32'(0));
            chk("reset_busy", 32'(busy[k]), 32'(0));
            chk("reset_pulses", 32'({rx_valid[k], underrun[k], frame_err[k]}), 32'(0));
        end
        rst = 1'b1;
        tick(6);

        run_frame(0, 1, 8'hAC, 8'h00, 1, 8'h5A, 8'h00, -1);
        for (int m = 1; m < 4; m++)
            run_frame(m, 1, 8'h3C, 8'h00, 1, 8'hC3, 8'h00, -1);

        run_frame(0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, -1);
        run_frame(0, 2, 8'hA1, 8'h5E, 2, 8'h11, 8'h22, -1);
        run_frame(1, 2, 8'h0F, 8'hF0, 2, 8'h11, 8'h22, -1);

        run_frame(0, 1, 8'hAC, 8'h00, 1, 8'h5A, 8'h00, -1);
        run_frame(0, 1, 8'h55, 8'h00, 1, 8'h77, 8'h00, 3);
        run_frame(0, 1, 8'h69, 8'h00, 1, 8'h81, 8'h00, -1);

        for (int r = 0; r < 12; r++) begin
            int m    = $urandom_range(0, 3);
            int nw   = $urandom_range(1, 2);
            int nsup = $urandom_range(0, nw);
            run_frame(m, nw, DW'($urandom), DW'($urandom), nsup, DW'($urandom), DW'($urandom), -1);
        end

        // Reset in the middle of a mode-0 word, then SCLK keeps running with CS still low.
        cpol = 1'b0;
        cpha = 1'b0;
        sclk = 1'b0;
        tick(8);
        push(0, 8'h33);
        cs[0] = 1'b0;
        tick(10);
        for (int i = 0; i < 3; i++) sclk_cycle(0, 1'b1, g);
        rst = 1'b0;
        tick(1);
        chk("midrst_miso", 32'(miso[0]), 32'(0));
        chk("midrst_tx_ready", 32'(tx_ready[0]), 32'(1));
        chk("midrst_rx_data", 32'(rx_data[0]), 32'(0));
        chk("midrst_busy", 32'(busy[0]), 32'(0));
        chk("midrst_pulses", 32'({rx_valid[0], underrun[0], frame_err[0]}), 32'(0));
        rst   = 1'b1;
        rxv0  = rxv_cnt;
        ferr0 = ferr_cnt;
        for (int i = 0; i < 10; i++) sclk_cycle(0, 1'b0, g);
        chk("postrst_no_frame", 32'(busy[0]), 32'(0));
        chk("postrst_no_rx", 32'(rxv_cnt - rxv0), 32'(0));
        cs[0] = 1'b1;
        tick(10);
        chk("postrst_no_frame_err", 32'(ferr_cnt - ferr0), 32'(0));
        run_frame(0, 1, 8'h96, 8'h00, 1, 8'hE7, 8'h00, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
